// File: rtl/multi_chan_sym_delay_pkg.sv
// rtl/multi_chan_sym_delay_pkg.sv - shared defaults and channel packing helper for the symbol delay line
//
// Purpose: default tap depth / reset tap used by the top and lane modules, plus
// the slice macro that maps channel c onto bits [c*WIDTH +: WIDTH] of a packed bus.
package multi_chan_sym_delay_pkg;

    localparam int MAX_DELAY_DEF     = 30;
    localparam int DEFAULT_DELAY_DEF = 20;

endpackage

`define MCSD_CH(c, w) (c)*(w) +: (w)

// File: rtl/sym_delay_lane.sv
// rtl/sym_delay_lane.sv - one channel of the symbol delay line with a selectable output tap
//
// Purpose: WIDTH x (MAX_DELAY+1) shift register advanced at symbol rate, with a
// registered tap mux.
// Ports:
//   sys_clk, reset  - clock, asynchronous active-high reset
//   sym_clk_en      - advance the line by one symbol
//   flush           - synchronous clear of stages and output; wins over sym_clk_en
//   sig_in          - symbol entering stage 0
//   tap             - stage index driven to sig_out (already clamped by the caller)
//   sig_out         - registered copy of stage[tap]
module sym_delay_lane
    import multi_chan_sym_delay_pkg::*;
#(
    parameter int  WIDTH     = 2,
    parameter int  MAX_DELAY = MAX_DELAY_DEF,
    localparam int DW        = $clog2(MAX_DELAY + 1)
) (
    input  logic             sys_clk,
    input  logic             reset,
    input  logic             sym_clk_en,
    input  logic             flush,
    input  logic [WIDTH-1:0] sig_in,
    input  logic [DW-1:0]    tap,
    output logic [WIDTH-1:0] sig_out
);

    logic [WIDTH-1:0] stage_q [0:MAX_DELAY];
    logic [WIDTH-1:0] sig_out_q;

    always_ff @(posedge sys_clk or posedge reset) begin
        if (reset) begin
            for (int k = 0; k <= MAX_DELAY; k++) begin
                stage_q[k] <= '0;
            end
        end else if (flush) begin
            for (int k = 0; k <= MAX_DELAY; k++) begin
                stage_q[k] <= '0;
            end
        end else if (sym_clk_en) begin
            stage_q[0] <= sig_in;
            for (int k = 1; k <= MAX_DELAY; k++) begin
                stage_q[k] <= stage_q[k-1];
            end
        end
    end

    // Output is re-registered every sys_clk so a tap change shows up one clock
    // after cur_delay moves, with no combinational path from the index.
    always_ff @(posedge sys_clk or posedge reset) begin
        if (reset) begin
            sig_out_q <= '0;
        end else if (flush) begin
            sig_out_q <= '0;
        end else begin
            sig_out_q <= stage_q[tap];
        end
    end

    assign sig_out = sig_out_q;

endmodule

// File: rtl/multi_chan_sym_delay.sv
// rtl/multi_chan_sym_delay.sv - multi-channel symbol delay line with boundary-aligned tap changes
//
// Purpose: NCH parallel lanes sharing one tap index; owns the delay request /
// apply logic, fill tracking and status flags.
// Ports:
//   sys_clk, reset  - clock, asynchronous active-high reset
//   sym_clk_en      - symbol-rate enable (one sys_clk wide)
//   flush           - synchronous clear of line contents, fill and pending request
//   sig_in/sig_out  - NCH*WIDTH packed symbols, channel c at [c*WIDTH +: WIDTH]
//   delay_sel/ld    - requested tap and its capture strobe
//   out_valid       - selected tap holds data shifted in since reset/flush
//   delay_pend      - captured request waiting for a symbol boundary
//   cur_delay       - tap in use
//   delay_err       - sticky: a request exceeded MAX_DELAY
module multi_chan_sym_delay
    import multi_chan_sym_delay_pkg::*;
#(
    parameter int  NCH           = 2,
    parameter int  WIDTH         = 2,
    parameter int  MAX_DELAY     = MAX_DELAY_DEF,
    parameter int  DEFAULT_DELAY = DEFAULT_DELAY_DEF,
    localparam int DW            = $clog2(MAX_DELAY + 1)
) (
    input  logic                 sys_clk,
    input  logic                 reset,
    input  logic                 sym_clk_en,
    input  logic                 flush,
    input  logic [NCH*WIDTH-1:0] sig_in,
    input  logic [DW-1:0]        delay_sel,
    input  logic                 delay_ld,
    output logic [NCH*WIDTH-1:0] sig_out,
    output logic                 out_valid,
    output logic                 delay_pend,
    output logic [DW-1:0]        cur_delay,
    output logic                 delay_err
);

    localparam int            FW        = $clog2(MAX_DELAY + 2);
    localparam logic [FW-1:0] FILL_FULL = FW'(MAX_DELAY + 1);

    logic [DW-1:0] cur_delay_q, cur_delay_d;
    logic [DW-1:0] pend_val_q, pend_val_d;
    logic          pend_q, pend_d;
    logic          err_q, err_d;
    logic          valid_q, valid_d;
    logic [FW-1:0] fill_q, fill_d;
    logic          sel_over;

    assign sel_over = (delay_sel > DW'(MAX_DELAY));

    always_comb begin
        cur_delay_d = cur_delay_q;
        pend_val_d  = pend_val_q;
        pend_d      = pend_q;
        err_d       = err_q;
        fill_d      = fill_q;
        valid_d     = (int'(fill_q) > int'(cur_delay_q));

        if (flush) begin
            pend_d  = 1'b0;
            fill_d  = '0;
            valid_d = 1'b0;
        end else begin
            if (sym_clk_en && (fill_q != FILL_FULL)) begin
                fill_d = fill_q + 1'b1;
            end
            // A fresh load always wins over applying the older pending value,
            // so a strobe coincident with sym_clk_en waits for the next boundary.
            if (delay_ld) begin
                pend_val_d = sel_over ? DW'(MAX_DELAY) : delay_sel;
                pend_d     = 1'b1;
                if (sel_over) begin
                    err_d = 1'b1;
                end
            end else if (sym_clk_en && pend_q) begin
                cur_delay_d = pend_val_q;
                pend_d      = 1'b0;
            end
        end
    end

    always_ff @(posedge sys_clk or posedge reset) begin
        if (reset) begin
            cur_delay_q <= DW'(DEFAULT_DELAY);
            pend_val_q  <= DW'(DEFAULT_DELAY);
            pend_q      <= 1'b0;
            err_q       <= 1'b0;
            valid_q     <= 1'b0;
            fill_q      <= '0;
        end else begin
            cur_delay_q <= cur_delay_d;
            pend_val_q  <= pend_val_d;
            pend_q      <= pend_d;
            err_q       <= err_d;
            valid_q     <= valid_d;
            fill_q      <= fill_d;
        end
    end

    for (genvar c = 0; c < NCH; c++) begin : g_lane
        sym_delay_lane #(
            .WIDTH     (WIDTH),
            .MAX_DELAY (MAX_DELAY)
        ) u_lane (
            .sys_clk    (sys_clk),
            .reset      (reset),
            .sym_clk_en (sym_clk_en),
            .flush      (flush),
            .sig_in     (sig_in[`MCSD_CH(c, WIDTH)]),
            .tap        (cur_delay_q),
            .sig_out    (sig_out[`MCSD_CH(c, WIDTH)])
        );
    end

    assign out_valid  = valid_q;
    assign delay_pend = pend_q;
    assign cur_delay  = cur_delay_q;
    assign delay_err  = err_q;

endmodule

// File: tb/tb_multi_chan_sym_delay.sv
// tb/tb_multi_chan_sym_delay.sv - self-checking bench for multi_chan_sym_delay
module tb_multi_chan_sym_delay;

    logic       sys_clk = 1'b0;
    logic       reset;
    logic       sym_clk_en;
    logic       flush;
    logic [3:0] sig_in;
    logic [4:0] delay_sel;
    logic       delay_ld;
    logic [3:0] sig_out;
    logic       out_valid;
    logic       delay_pend;
    logic [4:0] cur_delay;
    logic       delay_err;

    multi_chan_sym_delay #(
        .NCH           (2),
        .WIDTH         (2),
        .MAX_DELAY     (30),
        .DEFAULT_DELAY (20)
    ) dut (
        .sys_clk    (sys_clk),
        .reset      (reset),
        .sym_clk_en (sym_clk_en),
        .flush      (flush),
        .sig_in     (sig_in),
        .delay_sel  (delay_sel),
        .delay_ld   (delay_ld),
        .sig_out    (sig_out),
        .out_valid  (out_valid),
        .delay_pend (delay_pend),
        .cur_delay  (cur_delay),
        .delay_err  (delay_err)
    );

    always #5 sys_clk = ~sys_clk;

    int checks = 0;
    int errors = 0;

    // Reference model: shift history, fill count, tap and request state.
    int mhist [0:30];
    int mfill;
    int mcur;
    int mpend_v;
    int mpend_f;
    int merr;

    typedef struct {
        int sel;
        int sym;
        int exp_cur;
        int exp_err;
    } clamp_vec_t;

    clamp_vec_t vecs [5];

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge sys_clk);
        #1;
    endtask

    task automatic model_clear();
        for (int k = 0; k <= 30; k++) mhist[k] = 0;
        mfill = 0;
    endtask

    function automatic int clampv(input int s);
        return (s > 30) ? 30 : s;
    endfunction

    // One symbol: enable pulse (optionally with a coincident load), then three idle clocks.
    task automatic sym(input int v, input bit ld, input int sel);
        sym_clk_en = 1'b1;
        sig_in     = v[3:0];
        delay_ld   = ld;
        delay_sel  = sel[4:0];
        tick();
        sym_clk_en = 1'b0;
        delay_ld   = 1'b0;
        sig_in     = '0;
        for (int k = 30; k > 0; k--) mhist[k] = mhist[k-1];
        mhist[0] = v & 15;
        if (mfill < 31) mfill++;
        if (ld) begin
            mpend_v = clampv(sel);
            mpend_f = 1;
            if (sel > 30) merr = 1;
        end else if (mpend_f != 0) begin
            mcur    = mpend_v;
            mpend_f = 0;
        end
        tick();
        tick();
        tick();
    endtask

    task automatic ld_req(input int sel);
        delay_sel = sel[4:0];
        delay_ld  = 1'b1;
        tick();
        delay_ld  = 1'b0;
        mpend_v   = clampv(sel);
        mpend_f   = 1;
        if (sel > 30) merr = 1;
    endtask

    task automatic check_data(input string tag);
        check({tag, ".sig_out"}, int'(sig_out), mhist[mcur]);
        check({tag, ".out_valid"}, int'(out_valid), (mfill > mcur) ? 1 : 0);
    endtask

    task automatic check_ctrl(input string tag);
        check({tag, ".cur_delay"}, int'(cur_delay), mcur);
        check({tag, ".delay_pend"}, int'(delay_pend), mpend_f);
        check({tag, ".delay_err"}, int'(delay_err), merr);
    endtask

    initial begin
        vecs[0] = '{sel: 5,  sym: 4'h3, exp_cur: 5,  exp_err: 0};
        vecs[1] = '{sel: 30, sym: 4'h9, exp_cur: 30, exp_err: 0};
        vecs[2] = '{sel: 31, sym: 4'hA, exp_cur: 30, exp_err: 1};
        vecs[3] = '{sel: 0,  sym: 4'h4, exp_cur: 0,  exp_err: 1};
        vecs[4] = '{sel: 12, sym: 4'hE, exp_cur: 12, exp_err: 1};

        reset      = 1'b1;
        sym_clk_en = 1'b0;
        flush      = 1'b0;
        sig_in     = '0;
        delay_sel  = '0;
        delay_ld   = 1'b0;
        model_clear();
        mcur = 20; mpend_v = 20; mpend_f = 0; merr = 0;
        tick();
        tick();
        check("rst.sig_out", int'(sig_out), 0);
        check("rst.out_valid", int'(out_valid), 0);
        check_ctrl("rst");
        reset = 1'b0;
        tick();

        // Impulse at delay 20: appears after 21 symbols, out_valid rises with it.
        sym(4'b1101, 1'b0, 0);
        check_data("imp1");
        for (int i = 2; i <= 24; i++) begin
            sym(0, 1'b0, 0);
            check_data($sformatf("imp%0d", i));
            if (i == 20) check("imp_valid_before", int'(out_valid), 0);
            if (i == 21) begin
                check("imp_out", int'(sig_out), 4'b1101);
                check("imp_valid", int'(out_valid), 1);
            end
        end
        for (int i = 0; i < 6; i++) begin
            sym((i * 7 + 3) & 15, 1'b0, 0);
            check_data($sformatf("stream%0d", i));
        end

        // Mid-stream change to 9: pending until the next symbol boundary.
        ld_req(9);
        check_ctrl("chg_pend");
        tick();
        tick();
        check("chg_hold", int'(cur_delay), 20);
        sym(4'h5, 1'b0, 0);
        check_ctrl("chg_apply");
        check_data("chg_apply");
        for (int i = 0; i < 4; i++) begin
            sym((i * 5 + 1) & 15, 1'b0, 0);
            check_data($sformatf("chg%0d", i));
        end

        // Load coincident with sym_clk_en is captured, applied one symbol later.
        sym(4'h6, 1'b1, 15);
        check("same_cur", int'(cur_delay), 9);
        check("same_pend", int'(delay_pend), 1);
        check_data("same0");
        sym(4'h7, 1'b0, 0);
        check("same_cur_next", int'(cur_delay), 15);
        check_ctrl("same1");
        check_data("same1");

        // Table of requests including the clamp boundary.
        for (int i = 0; i < 5; i++) begin
            ld_req(vecs[i].sel);
            sym(vecs[i].sym, 1'b0, 0);
            check($sformatf("vec%0d.cur", i), int'(cur_delay), vecs[i].exp_cur);
            check($sformatf("vec%0d.err", i), int'(delay_err), vecs[i].exp_err);
            check($sformatf("vec%0d.pend", i), int'(delay_pend), 0);
            check_data($sformatf("vec%0d", i));
        end

        // Flush wins over a coincident shift and load; cur_delay and err kept.
        flush      = 1'b1;
        sym_clk_en = 1'b1;
        delay_ld   = 1'b1;
        delay_sel  = 5'd3;
        sig_in     = 4'hF;
        tick();
        flush      = 1'b0;
        sym_clk_en = 1'b0;
        delay_ld   = 1'b0;
        sig_in     = '0;
        model_clear();
        mpend_f = 0;
        check("flush.sig_out", int'(sig_out), 0);
        check("flush.out_valid", int'(out_valid), 0);
        check_ctrl("flush");
        tick();
        for (int i = 1; i <= 14; i++) begin
            sym((i * 3 + 2) & 15, 1'b0, 0);
            check_data($sformatf("refill%0d", i));
            if (i == 12) check("refill_valid_lo", int'(out_valid), 0);
            if (i == 13) check("refill_valid_hi", int'(out_valid), 1);
        end
        check("flush_cur_kept", int'(cur_delay), 12);

        // Async reset between symbols with a request pending.
        ld_req(7);
        check("areset_pend_before", int'(delay_pend), 1);
        #3;
        reset = 1'b1;
        #1;
        model_clear();
        mcur = 20; mpend_f = 0; merr = 0;
        check("areset.sig_out", int'(sig_out), 0);
        check("areset.out_valid", int'(out_valid), 0);
        check_ctrl("areset");
        tick();
        reset = 1'b0;
        tick();
        check_ctrl("areset_rel");
        for (int i = 0; i < 3; i++) begin
            sym(4'h8 + i, 1'b0, 0);
            check_data($sformatf("post%0d", i));
            check_ctrl($sformatf("post%0d", i));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
